uart_rx_frame: RTL and testbench



---
 rtl/uart_pkg.sv | 13 +
 rtl/rx_sync.sv | 22 ++
 rtl/uart_rx_frame.sv | 119 +++++++++++
 tb/tb_uart_rx_frame.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: deframer state encoding and frame geometry.
// The TX side imports the same package.
package uart_pkg;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] STOP  = 3'd3;
    localparam logic [2:0] BREAK = 3'd4;

    localparam int DATA_BITS = 8;

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchroniser for the asynchronous rx pin.
// Both flops reset high, which matches an idle line.
module rx_sync (
    input  logic clk,
    input  logic resetn,
    input  logic din,
    output logic dout
);

    logic meta;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            meta <= 1'b1;
            dout <= 1'b1;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_frame.sv
// 8N1 UART receive deframer: hunts for a start edge, samples each bit at
// its cell centre, checks the stop bit and strobes a good byte or a fault.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 27000000,
    parameter int BAUD   = 115200
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       rx,
    output logic       byte_ready,
    output logic [7:0] data,
    output logic       frame_err,
    output logic       busy
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);

    // Counter values just before the sampling edge.
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] CELL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       LAST_BIT  = 3'(DATA_BITS - 1);

    if (CLKS_PER_BIT < 4) begin : g_bad_cfg
        $error("uart_rx_frame: CLK_HZ/BAUD must be at least 4");
    end

    logic                 sync_rx;
    logic [2:0]           state;
    logic [2:0]           bit_idx;
    logic [CNT_W-1:0]     baud_cnt;
    logic [DATA_BITS-1:0] shift_reg;

    rx_sync u_rx_sync (
        .clk    (clk),
        .resetn (resetn),
        .din    (rx),
        .dout   (sync_rx)
    );

    assign busy = (state != IDLE);

    // The counter restarts at every sample point so each sample lands
    // a whole number of bit cells after the start-bit centre.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            bit_idx    <= 3'd0;
            baud_cnt   <= '0;
            shift_reg  <= '0;
            data       <= 8'h00;
            byte_ready <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_ready <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    if (!sync_rx) begin
                        state <= START;
                    end
                end
                START: begin
                    if (baud_cnt == HALF_LAST) begin
                        baud_cnt <= '0;
                        bit_idx  <= 3'd0;
                        state    <= sync_rx ? IDLE : DATA;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (baud_cnt == CELL_LAST) begin
                        baud_cnt  <= '0;
                        shift_reg <= {sync_rx, shift_reg[DATA_BITS-1:1]};
                        if (bit_idx == LAST_BIT) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (baud_cnt == CELL_LAST) begin
                        baud_cnt <= '0;
                        if (sync_rx) begin
                            data       <= shift_reg;
                            byte_ready <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                // A line held low after a bad stop bit must not look like a new start.
                BREAK: begin
                    baud_cnt <= '0;
                    if (sync_rx) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    baud_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame: directed and random frames, with a
// scoreboard of expected pulses checked by an independent monitor.
module tb_uart_rx_frame;

    localparam int CPB  = 10;
    localparam int HALF = 5;

    logic       clk    = 1'b0;
    logic       resetn = 1'b0;
    logic       rx     = 1'b1;
    logic       byte_ready;
    logic       frame_err;
    logic       busy;
    logic [7:0] data;

    typedef struct {
        bit         is_err;
        logic [7:0] value;
    } exp_t;

    exp_t       sb[$];
    int         pulse_cycles[$];
    int         checks    = 0;
    int         errors    = 0;
    int         cycle     = 0;
    logic [7:0] last_good = 8'h00;
    logic       prev_ready = 1'b0;
    logic       prev_err   = 1'b0;
    exp_t       mon_exp;

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    uart_rx_frame #(
        .CLK_HZ (1000000),
        .BAUD   (100000)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .rx         (rx),
        .byte_ready (byte_ready),
        .data       (data),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Monitor: every pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (resetn && (byte_ready || frame_err)) begin
            checkOutput("pulse_exclusive", {31'b0, byte_ready & frame_err}, 32'd0);
            if (byte_ready) begin
                checkOutput("ready_width", {31'b0, prev_ready}, 32'd0);
                pulse_cycles.push_back(cycle);
            end
            if (frame_err) begin
                checkOutput("err_width", {31'b0, prev_err}, 32'd0);
            end
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_pulse: got ready=%0b err=%0b data=%0h expected no pulse",
                         byte_ready, frame_err, data);
            end else begin
                mon_exp = sb.pop_front();
                checkOutput("pulse_kind", {31'b0, frame_err}, {31'b0, mon_exp.is_err});
                checkOutput("pulse_data", {24'b0, data}, {24'b0, mon_exp.value});
            end
        end
        prev_ready = byte_ready;
        prev_err   = frame_err;
    end

    task automatic driveCycle(input logic v);
        rx = v;
        @(posedge clk);
        #1;
    endtask

    task automatic driveIdle(input int n);
        for (int i = 0; i < n; i++) driveCycle(1'b1);
    endtask

    // perturb inverts the line one clock either side of each start/data cell centre.
    task automatic applyStimulus(input logic [7:0] b, input logic stop_bit,
                                 input int hold_low, input bit perturb, input int gap);
        exp_t       e;
        logic [9:0] frame_bits;
        logic       v;
        e.is_err = !stop_bit;
        e.value  = stop_bit ? b : last_good;
        if (stop_bit) last_good = b;
        sb.push_back(e);
        frame_bits = {stop_bit, b, 1'b0};
        for (int c = 0; c < 10; c++) begin
            for (int k = 0; k < CPB; k++) begin
                v = frame_bits[c];
                if (perturb && c < 9 && (k == HALF - 1 || k == HALF + 1)) v = ~v;
                driveCycle(v);
            end
        end
        for (int i = 0; i < hold_low; i++) driveCycle(1'b0);
        driveIdle(gap);
    endtask

    initial begin
        #1000000;
        checks++;
        errors++;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        logic [7:0] rb;
        logic       rs;
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_ready", {31'b0, byte_ready}, 32'd0);
        checkOutput("reset_err", {31'b0, frame_err}, 32'd0);
        checkOutput("reset_busy", {31'b0, busy}, 32'd0);
        checkOutput("reset_data", {24'b0, data}, 32'h00);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        driveIdle(5);

        $display("[TB] single frame 0x55");
        applyStimulus(8'h55, 1'b1, 0, 1'b0, 20);
        checkOutput("drain_55", sb.size(), 32'd0);

        $display("[TB] back-to-back 0xA3, 0x0F");
        pulse_cycles.delete();
        applyStimulus(8'hA3, 1'b1, 0, 1'b0, 0);
        applyStimulus(8'h0F, 1'b1, 0, 1'b0, 20);
        checkOutput("b2b_count", pulse_cycles.size(), 32'd2);
        if (pulse_cycles.size() == 2)
            checkOutput("b2b_spacing", pulse_cycles[1] - pulse_cycles[0], 32'd100);
        checkOutput("drain_b2b", sb.size(), 32'd0);

        $display("[TB] 3-clock glitch");
        driveCycle(1'b0);
        driveCycle(1'b0);
        driveCycle(1'b0);
        driveIdle(2);
        checkOutput("glitch_busy_start", {31'b0, busy}, 32'd1);
        driveIdle(3);
        checkOutput("glitch_idle_by_e5", {31'b0, busy}, 32'd0);
        driveIdle(20);
        checkOutput("drain_glitch", sb.size(), 32'd0);

        $display("[TB] bad stop on 0x81 with held-low line");
        applyStimulus(8'h81, 1'b0, 40, 1'b0, 0);
        checkOutput("break_busy_low", {31'b0, busy}, 32'd1);
        driveIdle(2);
        checkOutput("break_busy_release", {31'b0, busy}, 32'd1);
        driveIdle(2);
        checkOutput("break_busy_idle", {31'b0, busy}, 32'd0);
        driveIdle(20);
        checkOutput("data_after_err", {24'b0, data}, {24'b0, last_good});
        checkOutput("drain_err", sb.size(), 32'd0);

        $display("[TB] reset during data bit 4 of 0xFF");
        for (int i = 0; i < CPB; i++) driveCycle(1'b0);
        for (int i = 0; i < 4 * CPB + HALF; i++) driveCycle(1'b1);
        #2;
        resetn = 1'b0;
        #1;
        checkOutput("midreset_data", {24'b0, data}, 32'h00);
        checkOutput("midreset_busy", {31'b0, busy}, 32'd0);
        checkOutput("midreset_ready", {31'b0, byte_ready}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        last_good = 8'h00;
        @(posedge clk);
        #1;
        driveIdle(3 * CPB + HALF + CPB + 10);
        checkOutput("drain_midreset", sb.size(), 32'd0);
        applyStimulus(8'h3C, 1'b1, 0, 1'b0, 20);
        checkOutput("data_3c", {24'b0, data}, 32'h3C);
        checkOutput("drain_3c", sb.size(), 32'd0);

        $display("[TB] centre-sampling frames");
        applyStimulus(8'hB6, 1'b1, 0, 1'b1, 5);
        applyStimulus(8'h49, 1'b1, 0, 1'b1, 20);
        checkOutput("drain_centre", sb.size(), 32'd0);

        $display("[TB] random frames");
        for (int n = 0; n < 12; n++) begin
            rb = 8'($urandom);
            rs = ($urandom_range(0, 3) != 0);
            applyStimulus(rb, rs, rs ? 0 : int'($urandom_range(0, 20)),
                          bit'($urandom_range(0, 1)),
                          rs ? int'($urandom_range(0, 8)) : int'($urandom_range(2, 8)));
        end
        driveIdle(20);
        checkOutput("drain_random", sb.size(), 32'd0);
        checkOutput("final_data", {24'b0, data}, {24'b0, last_good});
        checkOutput("final_busy", {31'b0, busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
